// File: rtl/major_state_seq_pkg.sv
// Shared types and constants for the PDP-8 major-state sequencer.
package major_state_seq_pkg;

  typedef enum logic [1:0] {
    MS_IDLE  = 2'd0,
    MS_FETCH = 2'd1,
    MS_DEFER = 2'd2,
    MS_EXEC  = 2'd3
  } ms_state_e;

  localparam logic [2:0] OP_JMP = 3'd5;
  localparam logic [2:0] OP_IOT = 3'd6;
  localparam logic [2:0] OP_OPR = 3'd7;

  localparam int TP_W = 4;

  // True when the instruction finishes at the end of this state's T4.
  function automatic logic inst_complete(ms_state_e st, logic [2:0] op, logic ind);
    case (st)
      MS_FETCH: inst_complete = (op == OP_IOT) || (op == OP_OPR) || ((op == OP_JMP) && !ind);
      MS_DEFER: inst_complete = (op == OP_JMP);
      MS_EXEC:  inst_complete = 1'b1;
      default:  inst_complete = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/major_state_seq_timing_gen.sv
// Time-pulse generator: T1..T4 tick counter with T2 memory stall and T2-entry strobe.
module timing_gen
  import major_state_seq_pkg::*;
(
  input  logic            i_clk_sys,
  input  logic            i_rst_b,
  input  logic            i_en,
  input  logic            i_mem_wait,
  output logic [TP_W-1:0] o_tp,
  output logic            o_last_tick,
  output logic            o_t2_stb
);

  logic [1:0] r_tick;
  logic       r_t2_stb;

  always_ff @(posedge i_clk_sys) begin
    if (!i_rst_b) begin
      r_tick   <= 2'd0;
      r_t2_stb <= 1'b0;
    end else begin
      // T1 never stalls, so leaving T1 always lands on the first T2 cycle.
      r_t2_stb <= i_en && (r_tick == 2'd0);
      if (!i_en)
        r_tick <= 2'd0;
      else if (!((r_tick == 2'd1) && i_mem_wait))
        r_tick <= r_tick + 2'd1;
    end
  end

  assign o_tp        = i_en ? (TP_W'(1) << r_tick) : '0;
  assign o_last_tick = i_en && (r_tick == 2'd3);
  assign o_t2_stb    = r_t2_stb;

endmodule

// File: rtl/major_state_seq.sv
// PDP-8 major-state sequencer: steps FETCH/DEFER/EXEC and issues per-state strobes.
//
// state    | meaning
// MS_IDLE  | stopped; waits for run or step
// MS_FETCH | instruction fetch, ckFetch loads IR
// MS_DEFER | indirect address fetch
// MS_EXEC  | operand execute cycle
module major_state_seq
  import major_state_seq_pkg::*;
(
  input  logic            SYSCLK,
  input  logic            RESET,
  input  logic            run,
  input  logic            step,
  input  logic            hlt,
  input  logic            memWait,
  input  logic [2:0]      irOpcode,
  input  logic            irIndirect,
  output logic            stFetch,
  output logic            stDefer,
  output logic            stExec,
  output logic [TP_W-1:0] tp,
  output logic            ckFetch,
  output logic            ckDefer,
  output logic            ckExec,
  output logic            instDone,
  output logic            running
);

  ms_state_e r_state;
  logic      r_single;
  logic      r_inst_done;

  logic            w_running;
  logic            w_last;
  logic            w_t2_stb;
  logic [TP_W-1:0] w_tp;
  logic            w_complete;
  logic            w_stop;

  assign w_running  = (r_state != MS_IDLE);
  assign w_complete = inst_complete(r_state, irOpcode, irIndirect);
  assign w_stop     = !run || r_single || ((irOpcode == OP_OPR) && hlt);

  timing_gen u_timing (
    .i_clk_sys   (SYSCLK),
    .i_rst_b     (RESET),
    .i_en        (w_running),
    .i_mem_wait  (memWait),
    .o_tp        (w_tp),
    .o_last_tick (w_last),
    .o_t2_stb    (w_t2_stb)
  );

  always_ff @(posedge SYSCLK) begin
    if (!RESET) begin
      r_state     <= MS_IDLE;
      r_single    <= 1'b0;
      r_inst_done <= 1'b0;
    end else begin
      // Set on the T3->T4 edge so the pulse covers exactly the final T4.
      r_inst_done <= w_tp[2] && w_complete;
      case (r_state)
        MS_IDLE: begin
          if (run || step) begin
            r_state  <= MS_FETCH;
            r_single <= step;
          end
        end
        default: begin
          if (w_last) begin
            if (w_complete) begin
              if (w_stop) begin
                r_state  <= MS_IDLE;
                r_single <= 1'b0;
              end else begin
                r_state <= MS_FETCH;
              end
            end else if ((r_state == MS_FETCH) && irIndirect) begin
              r_state <= MS_DEFER;
            end else begin
              r_state <= MS_EXEC;
            end
          end
        end
      endcase
    end
  end

  assign stFetch  = (r_state == MS_FETCH);
  assign stDefer  = (r_state == MS_DEFER);
  assign stExec   = (r_state == MS_EXEC);
  assign tp       = w_tp;
  assign ckFetch  = w_t2_stb && (r_state == MS_FETCH);
  assign ckDefer  = w_t2_stb && (r_state == MS_DEFER);
  assign ckExec   = w_t2_stb && (r_state == MS_EXEC);
  assign instDone = r_inst_done;
  assign running  = w_running;

endmodule

// File: tb/tb_major_state_seq.sv
// Scoreboard bench for major_state_seq: expected per-cycle output vectors are queued, then popped each cycle.
module tb_major_state_seq;

  logic       SYSCLK = 1'b0;
  logic       RESET = 1'b0;
  logic       run = 1'b0;
  logic       step = 1'b0;
  logic       hlt = 1'b0;
  logic       memWait = 1'b0;
  logic [2:0] irOpcode = 3'd0;
  logic       irIndirect = 1'b0;
  logic       stFetch, stDefer, stExec;
  logic [3:0] tp;
  logic       ckFetch, ckDefer, ckExec, instDone, running;

  int checks = 0;
  int errors = 0;
  logic [11:0] q_exp[$];

  major_state_seq dut (
    .SYSCLK    (SYSCLK),
    .RESET     (RESET),
    .run       (run),
    .step      (step),
    .hlt       (hlt),
    .memWait   (memWait),
    .irOpcode  (irOpcode),
    .irIndirect(irIndirect),
    .stFetch   (stFetch),
    .stDefer   (stDefer),
    .stExec    (stExec),
    .tp        (tp),
    .ckFetch   (ckFetch),
    .ckDefer   (ckDefer),
    .ckExec    (ckExec),
    .instDone  (instDone),
    .running   (running)
  );

  always #5 SYSCLK = ~SYSCLK;

  // Vector: {stF,stD,stE, tp[3:0], ckF,ckD,ckE, instDone, running}; st 0=idle 1=F 2=D 3=E
  function automatic logic [11:0] mk(int st, int tpi, bit ck, bit done);
    logic [2:0] s;
    logic [3:0] t;
    logic [2:0] c;
    s = (st == 1) ? 3'b100 : (st == 2) ? 3'b010 : (st == 3) ? 3'b001 : 3'b000;
    t = (st != 0) ? (4'b0001 << tpi) : 4'b0000;
    c = ck ? s : 3'b000;
    return {s, t, c, done, (st != 0)};
  endfunction

  function automatic logic [11:0] actual();
    return {stFetch, stDefer, stExec, tp, ckFetch, ckDefer, ckExec, instDone, running};
  endfunction

  task automatic push_state(input int st, input int t2len, input bit done);
    for (int tpi = 0; tpi < 4; tpi++) begin
      int reps;
      reps = (tpi == 1) ? t2len : 1;
      for (int r = 0; r < reps; r++)
        q_exp.push_back(mk(st, tpi, (tpi == 1) && (r == 0), (tpi == 3) && done));
    end
  endtask

  task automatic push_idle(input int n);
    for (int k = 0; k < n; k++) q_exp.push_back(12'h000);
  endtask

  // Edge i: run=(i<run_off), step=(i<step_off), memWait within window, RESET low at rst_edge.
  task automatic run_trace(input string name, input int run_off, input int step_off,
                           input int mw_start, input int mw_len, input int rst_edge);
    int i;
    logic [11:0] exp_v;
    logic [11:0] act_v;
    i = 0;
    while (q_exp.size() > 0) begin
      run     = (i < run_off);
      step    = (i < step_off);
      memWait = (i >= mw_start) && (i < mw_start + mw_len);
      RESET   = (i != rst_edge);
      @(posedge SYSCLK);
      #1;
      exp_v = q_exp.pop_front();
      act_v = actual();
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL %s cycle %0d got %h want %h", name, i, act_v, exp_v);
      end
      i++;
    end
    run = 1'b0; step = 1'b0; memWait = 1'b0; RESET = 1'b1;
  endtask

  task automatic test_reset();
    RESET = 1'b0; run = 1'b1; step = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge SYSCLK);
      #1;
      checks++;
      if (actual() !== 12'h000) begin
        errors++;
        $display("FAIL reset cycle %0d got %h want %h", k, actual(), 12'h000);
      end
    end
    RESET = 1'b1; run = 1'b0; step = 1'b0;
    @(posedge SYSCLK);
    #1;
  endtask

  task automatic test_opr_loop();
    irOpcode = 3'd7; irIndirect = 1'b0; hlt = 1'b0;
    for (int k = 0; k < 3; k++) push_state(1, 1, 1'b1);
    push_idle(1);
    run_trace("opr_loop", 12, 0, 1, 1, -1);
  endtask

  task automatic test_tad_indirect();
    irOpcode = 3'd1; irIndirect = 1'b1;
    push_state(1, 1, 1'b0);
    push_state(2, 1, 1'b0);
    push_state(3, 1, 1'b1);
    push_idle(1);
    run_trace("tad_ind", 12, 0, -10, 0, -1);
  endtask

  task automatic test_jmp();
    irOpcode = 3'd5; irIndirect = 1'b0;
    push_state(1, 1, 1'b1);
    push_idle(1);
    run_trace("jmp_dir", 4, 0, -10, 0, -1);
    irIndirect = 1'b1;
    push_state(1, 1, 1'b0);
    push_state(2, 1, 1'b1);
    push_idle(1);
    run_trace("jmp_ind", 8, 0, -10, 0, -1);
  endtask

  task automatic test_mem_wait();
    irOpcode = 3'd7; irIndirect = 1'b0;
    push_state(1, 4, 1'b1);
    push_idle(1);
    run_trace("mem_wait", 7, 0, 2, 3, -1);
  endtask

  task automatic test_step();
    irOpcode = 3'd3; irIndirect = 1'b0;
    push_state(1, 1, 1'b0);
    push_state(3, 1, 1'b1);
    push_idle(2);
    run_trace("step_dca", 0, 1, -10, 0, -1);
  endtask

  task automatic test_back_to_back();
    irOpcode = 3'd3; irIndirect = 1'b0;
    push_state(1, 1, 1'b0);
    push_state(3, 1, 1'b1);
    push_idle(1);
    push_state(1, 1, 1'b0);
    push_state(3, 1, 1'b1);
    push_idle(2);
    run_trace("step_held", 0, 10, -10, 0, -1);
  endtask

  task automatic test_hlt();
    irOpcode = 3'd7; irIndirect = 1'b0; hlt = 1'b1;
    push_state(1, 1, 1'b1);
    push_idle(2);
    run_trace("hlt", 5, 0, -10, 0, -1);
    hlt = 1'b0;
  endtask

  task automatic test_reset_abort();
    irOpcode = 3'd1; irIndirect = 1'b0;
    push_state(1, 1, 1'b0);
    q_exp.push_back(mk(3, 0, 1'b0, 1'b0));
    q_exp.push_back(mk(3, 1, 1'b1, 1'b0));
    q_exp.push_back(mk(3, 2, 1'b0, 1'b0));
    push_idle(1);
    push_state(1, 1, 1'b0);
    push_state(3, 1, 1'b1);
    push_idle(1);
    run_trace("reset_abort", 16, 0, -10, 0, 7);
  endtask

  initial begin
    test_reset();
    test_opr_loop();
    test_tad_indirect();
    test_jmp();
    test_mem_wait();
    test_step();
    test_back_to_back();
    test_hlt();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
